// File: rtl/ksz8851_init_seq.sv
// Post-reset initialization sequencer for the KSZ8851 command port: verifies the chip ID,
// programs MAC/TX/RX/IRQ registers and checks the MAC readback, reporting initOK/initFail.
module ksz8851_init_seq #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRIES    = 3
) (
   input  logic        i_sysclk,
   input  logic        i_reset_n,
   input  logic        i_initReq,
   output logic        o_initAck,
   output logic        o_cmdReq,
   input  logic        i_cmdAck,
   input  logic        i_dataValid,
   output logic        o_isDMA,
   output logic        o_isWrite,
   output logic        o_isWord,
   output logic [7:0]  o_RegAddr,
   output logic [15:0] o_DataIn,
   input  logic [15:0] i_DataOut,
   input  logic [47:0] i_mac_addr,
   output logic        o_busy,
   output logic        o_initOK,
   output logic        o_initFail,
   output logic [1:0]  o_err_code,
   output logic [3:0]  o_step,
   output logic [3:0]  o_state
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
   localparam logic [3:0]    LAST_STEP  = 4'd8;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_CHIP_ID  = 2'd2;
   localparam logic [1:0] ERR_READBACK = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ACK       = 4'd1,
      ST_ISSUE     = 4'd2,
      ST_WAIT_ACK  = 4'd3,
      ST_WAIT_DATA = 4'd4,
      ST_RELEASE   = 4'd5,
      ST_NEXT      = 4'd6,
      ST_DONE      = 4'd7,
      ST_FAIL      = 4'd8
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] data;   // write data, or expected value for reads
      logic [15:0] mask;
   } entry_t;

   function automatic entry_t table_entry(input logic [3:0] idx, input logic [47:0] mac);
      entry_t e;
      e = '{wr: 1'b0, addr: 8'hC0, data: 16'h8870, mask: 16'hFFF0};
      case (idx)
         4'd1:    e = '{wr: 1'b1, addr: 8'h10, data: mac[15:0],  mask: 16'hFFFF};
         4'd2:    e = '{wr: 1'b1, addr: 8'h12, data: mac[31:16], mask: 16'hFFFF};
         4'd3:    e = '{wr: 1'b1, addr: 8'h14, data: mac[47:32], mask: 16'hFFFF};
         4'd4:    e = '{wr: 1'b1, addr: 8'h84, data: 16'h4000,   mask: 16'hFFFF};
         4'd5:    e = '{wr: 1'b1, addr: 8'h70, data: 16'h00EE,   mask: 16'hFFFF};
         4'd6:    e = '{wr: 1'b1, addr: 8'h74, data: 16'h7CE0,   mask: 16'hFFFF};
         4'd7:    e = '{wr: 1'b1, addr: 8'h90, data: 16'h2000,   mask: 16'hFFFF};
         4'd8:    e = '{wr: 1'b0, addr: 8'h10, data: mac[15:0],  mask: 16'hFFFF};
         default: ;
      endcase
      return e;
   endfunction

   state_t         r_state, w_state;
   logic [3:0]     r_step, w_step;
   logic [RW-1:0]  r_retries, w_retries;
   logic [TW-1:0]  r_timer, w_timer;
   logic [47:0]    r_mac, w_mac;
   logic           r_mismatch, w_mismatch;
   logic           r_cmd_req, w_cmd_req;
   logic           r_is_write, w_is_write;
   logic           r_is_word, w_is_word;
   logic [7:0]     r_reg_addr, w_reg_addr;
   logic [15:0]    r_data_in, w_data_in;
   logic           r_init_ack, w_init_ack;
   logic           r_busy, w_busy;
   logic           r_init_ok, w_init_ok;
   logic           r_init_fail, w_init_fail;
   logic [1:0]     r_err, w_err;
   entry_t         w_entry;
   logic           w_timeout;

   assign w_entry   = table_entry(r_step, r_mac);
   assign w_timeout = (r_timer == TIMER_LAST);

   // Command port handshake: cmdReq rises together with stable RegAddr/DataIn/isWrite,
   // is held until cmdAck (writes) or dataValid (reads), and is only raised again after
   // cmdAck has been seen low, which also guarantees at least one idle cycle between commands.
   always_comb begin
      w_state     = r_state;
      w_step      = r_step;
      w_retries   = r_retries;
      w_timer     = r_timer;
      w_mac       = r_mac;
      w_mismatch  = r_mismatch;
      w_cmd_req   = r_cmd_req;
      w_is_write  = r_is_write;
      w_is_word   = 1'b1;
      w_reg_addr  = r_reg_addr;
      w_data_in   = r_data_in;
      w_init_ack  = r_init_ack;
      w_busy      = r_busy;
      w_init_ok   = r_init_ok;
      w_init_fail = r_init_fail;
      w_err       = r_err;

      if (i_initReq && r_state != ST_IDLE && r_state != ST_ACK) begin
         // Chip was reset under us: abandon the pending command and start over.
         w_state    = ST_ACK;
         w_cmd_req  = 1'b0;
         w_init_ack = 1'b1;
         w_timer    = '0;
         w_mismatch = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_initReq) begin
                  w_state    = ST_ACK;
                  w_init_ack = 1'b1;
               end
            end
            ST_ACK: begin
               if (!i_initReq) begin
                  w_init_ack  = 1'b0;
                  w_init_ok   = 1'b0;
                  w_init_fail = 1'b0;
                  w_err       = ERR_NONE;
                  w_step      = '0;
                  w_retries   = '0;
                  w_mac       = i_mac_addr;
                  w_busy      = 1'b1;
                  w_state     = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               w_is_write = w_entry.wr;
               w_reg_addr = w_entry.addr;
               w_data_in  = w_entry.wr ? w_entry.data : 16'h0000;
               w_cmd_req  = 1'b1;
               w_timer    = '0;
               w_mismatch = 1'b0;
               w_state    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (i_cmdAck) begin
                  w_timer = '0;
                  if (r_is_write) begin
                     w_cmd_req = 1'b0;
                     w_state   = ST_RELEASE;
                  end else begin
                     w_state = ST_WAIT_DATA;
                  end
               end else if (w_timeout) begin
                  w_cmd_req = 1'b0;
                  w_err     = ERR_TIMEOUT;
                  w_state   = ST_FAIL;
               end else begin
                  w_timer = r_timer + 1'b1;
               end
            end
            ST_WAIT_DATA: begin
               if (i_dataValid) begin
                  w_mismatch = ((i_DataOut & w_entry.mask) != w_entry.data);
                  w_cmd_req  = 1'b0;
                  w_timer    = '0;
                  w_state    = ST_RELEASE;
               end else if (w_timeout) begin
                  w_cmd_req = 1'b0;
                  w_err     = ERR_TIMEOUT;
                  w_state   = ST_FAIL;
               end else begin
                  w_timer = r_timer + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!i_cmdAck) begin
                  if (r_mismatch && r_step == 4'd0) begin
                     if (r_retries < RETRY_MAX) begin
                        w_retries = r_retries + 1'b1;
                        w_state   = ST_ISSUE;
                     end else begin
                        w_err   = ERR_CHIP_ID;
                        w_state = ST_FAIL;
                     end
                  end else if (r_mismatch) begin
                     w_err   = ERR_READBACK;
                     w_state = ST_FAIL;
                  end else begin
                     w_state = ST_NEXT;
                  end
               end else if (w_timeout) begin
                  w_err   = ERR_TIMEOUT;
                  w_state = ST_FAIL;
               end else begin
                  w_timer = r_timer + 1'b1;
               end
            end
            ST_NEXT: begin
               if (r_step == LAST_STEP) begin
                  w_state = ST_DONE;
               end else begin
                  w_step  = r_step + 4'd1;
                  w_state = ST_ISSUE;
               end
            end
            ST_DONE: begin
               w_init_ok = 1'b1;
               w_busy    = 1'b0;
               w_state   = ST_IDLE;
            end
            ST_FAIL: begin
               w_init_fail = 1'b1;
               w_cmd_req   = 1'b0;
               w_busy      = 1'b0;
               w_state     = ST_IDLE;
            end
            default: w_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_sysclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_step      <= '0;
         r_retries   <= '0;
         r_timer     <= '0;
         r_mac       <= '0;
         r_mismatch  <= 1'b0;
         r_cmd_req   <= 1'b0;
         r_is_write  <= 1'b0;
         r_is_word   <= 1'b0;
         r_reg_addr  <= '0;
         r_data_in   <= '0;
         r_init_ack  <= 1'b0;
         r_busy      <= 1'b0;
         r_init_ok   <= 1'b0;
         r_init_fail <= 1'b0;
         r_err       <= ERR_NONE;
      end else begin
         r_state     <= w_state;
         r_step      <= w_step;
         r_retries   <= w_retries;
         r_timer     <= w_timer;
         r_mac       <= w_mac;
         r_mismatch  <= w_mismatch;
         r_cmd_req   <= w_cmd_req;
         r_is_write  <= w_is_write;
         r_is_word   <= w_is_word;
         r_reg_addr  <= w_reg_addr;
         r_data_in   <= w_data_in;
         r_init_ack  <= w_init_ack;
         r_busy      <= w_busy;
         r_init_ok   <= w_init_ok;
         r_init_fail <= w_init_fail;
         r_err       <= w_err;
      end
   end

   assign o_initAck  = r_init_ack;
   assign o_cmdReq   = r_cmd_req;
   assign o_isDMA    = 1'b0;
   assign o_isWrite  = r_is_write;
   assign o_isWord   = r_is_word;
   assign o_RegAddr  = r_reg_addr;
   assign o_DataIn   = r_data_in;
   assign o_busy     = r_busy;
   assign o_initOK   = r_init_ok;
   assign o_initFail = r_init_fail;
   assign o_err_code = r_err;
   assign o_step     = r_step;
   assign o_state    = r_state;

endmodule
